capture_ram: RTL and testbench

//   Write-side companion to the sine lookup ROM: captures a stream of samples into a

---
 rtl/capture_ram.sv | 111 +++++++++++
 tb/tb_capture_ram.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/capture_ram.sv
// capture_ram: circular sample capture RAM with delayed, registered read-back.
// Ports:
//   clk, rst (async, active-high)
//   start/stop      : begin / end a capture
//   din_valid, din  : sample write strobe and data (CAPTURE only)
//   offset          : read delay in samples, 0 = most recent write
//   dout, dout_valid: registered delayed sample, valid if within capture
//   busy, done      : CAPTURE / DONE state flags
//   count           : samples written this capture, saturates at DEPTH
// Build option: define CAPTURE_LOOP_EN for continuous delay-line mode
// (wraps and overwrites instead of stopping at DEPTH).
module capture_ram #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     din_valid,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic [ADDRESS_WIDTH-1:0] offset,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     dout_valid,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH:0]   count
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] FULL =
    (ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH:0] LAST =
    (ADDRESS_WIDTH+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic                     wr_en;
  logic                     enter;

  assign wr_en = (state == CAPTURE) && din_valid;
  assign enter = (state != CAPTURE) && (state_nx == CAPTURE);

  // Modular subtraction: offset 0 is the slot just behind wr_addr.
  assign rd_addr = wr_addr - ADDRESS_WIDTH'(1) - offset;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CAPTURE;
      DONE:    if (start) state_nx = CAPTURE;
      CAPTURE: begin
`ifdef CAPTURE_LOOP_EN
        if (stop) state_nx = DONE;
`else
        // The write that fills the last slot ends the capture.
        if (stop || (wr_en && count == LAST))
          state_nx = DONE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr <= '0;
      count   <= '0;
    end else if (enter) begin
      wr_addr <= '0;
      count   <= '0;
    end else if (wr_en) begin
      wr_addr <= wr_addr + ADDRESS_WIDTH'(1);
      if (count != FULL)
        count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= din;
  end

  // Read-first: a same-address write this edge is not seen here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout       <= mem[rd_addr];
      dout_valid <= ({1'b0, offset} < count);
    end
  end

  assign busy = (state == CAPTURE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_capture_ram.sv
// tb_capture_ram: directed checks of capture_ram at AW=4, DW=8.
// Expected values are hand-computed per vector.
module tb_capture_ram;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          din_valid = 1'b0;
  logic [DW-1:0] din = '0;
  logic [AW-1:0] offset = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          busy;
  logic          done;
  logic [AW:0]   count;

  int n_cmp = 0;
  int n_bad = 0;

  capture_ram #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .din_valid(din_valid),
    .din(din),
    .offset(offset),
    .dout(dout),
    .dout_valid(dout_valid),
    .busy(busy),
    .done(done),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    din_valid = 1'b1;
    din = d;
    cyc();
    din_valid = 1'b0;
  endtask

  initial begin
    // 1: async reset between clock edges
    #3 rst = 1'b1;
    #1;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_dv", 32'(dout_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    cyc();
    cyc();
    #2 rst = 1'b0;
    cyc();

    // din_valid in IDLE is ignored
    wr(8'h77);
    chk("idle_wr_count", 32'(count), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    // 2: five samples, offset reads
    do_start();
    chk("t2_busy", 32'(busy), 32'h1);
    offset = 4'd0;
    for (int i = 0; i < 5; i++) wr(8'(8'h10 + i));
    chk("t2_count", 32'(count), 32'd5);
    cyc();
    chk("t2_dout0", 32'(dout), 32'h14);
    chk("t2_dv0", 32'(dout_valid), 32'h1);
    offset = 4'd4;
    cyc();
    chk("t2_dout4", 32'(dout), 32'h10);
    chk("t2_dv4", 32'(dout_valid), 32'h1);
    offset = 4'd5;
    cyc();
    chk("t2_dv5", 32'(dout_valid), 32'h0);

    // start ignored in CAPTURE
    do_start();
    chk("t2_start_ign", 32'(count), 32'd5);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("t2_stop_done", 32'(done), 32'h1);

    // 3: fill all 16 slots
    do_start();
    chk("t3_busy", 32'(busy), 32'h1);
    chk("t3_count0", 32'(count), 32'h0);
    offset = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        chk("t3_busy15", 32'(busy), 32'h1);
      end
      wr(8'(i));
    end
    chk("t3_done", 32'(done), 32'h1);
    chk("t3_busy", 32'(busy), 32'h0);
    chk("t3_count", 32'(count), 32'd16);
    offset = 4'd15;
    wr(8'h55);
    chk("t3_count17", 32'(count), 32'd16);
    chk("t3_dout15", 32'(dout), 32'h00);
    chk("t3_dv15", 32'(dout_valid), 32'h1);
    cyc();
    chk("t3_nowrite", 32'(dout), 32'h00);

    // 4: stop together with the 3rd write
    do_start();
    offset = 4'd0;
    wr(8'hA1);
    wr(8'hA2);
    stop = 1'b1;
    wr(8'hA3);
    stop = 1'b0;
    chk("t4_done", 32'(done), 32'h1);
    chk("t4_count", 32'(count), 32'd3);
    cyc();
    chk("t4_dout", 32'(dout), 32'hA3);
    offset = 4'd1;
    cyc();
    chk("t4_dout1", 32'(dout), 32'hA2);
    do_start();
    chk("t4_busy", 32'(busy), 32'h1);
    chk("t4_count0", 32'(count), 32'h0);
    offset = 4'd7;
    cyc();
    chk("t4_dv7", 32'(dout_valid), 32'h0);
    offset = 4'd0;
    cyc();
    chk("t4_dv0", 32'(dout_valid), 32'h0);

`ifdef CAPTURE_LOOP_EN
    // 5: continuous mode wraps
    for (int i = 0; i < 20; i++) wr(8'(i));
    chk("t5_busy", 32'(busy), 32'h1);
    chk("t5_count", 32'(count), 32'd16);
    offset = 4'd0;
    cyc();
    chk("t5_dout0", 32'(dout), 32'h13);
    offset = 4'd15;
    cyc();
    chk("t5_dout15", 32'(dout), 32'h04);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("t5_done", 32'(done), 32'h1);
`else
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("t5_done", 32'(done), 32'h1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("t5_stop_ign", 32'(done), 32'h1);
`endif

    // 6: reset mid-capture, then restart
    do_start();
    for (int i = 0; i < 7; i++) wr(8'(8'h30 + i));
    chk("t6_count7", 32'(count), 32'd7);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_count", 32'(count), 32'h0);
    chk("t6_rst_dv", 32'(dout_valid), 32'h0);
    #2 rst = 1'b0;
    cyc();
    do_start();
    offset = 4'd0;
    wr(8'hAA);
    chk("t6_count", 32'(count), 32'd1);
    cyc();
    chk("t6_dout", 32'(dout), 32'hAA);
    chk("t6_dv0", 32'(dout_valid), 32'h1);
    offset = 4'd1;
    cyc();
    chk("t6_dv1", 32'(dout_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
